io_keys: RTL and testbench
==========================

# io_keys

Memory-mapped push-button peripheral for the single-cycle RISC-V system; sits upstream of the CPU read-data path in the I/O space alongside the LED and HEX output registers. Synchronises and debounces the active-low board keys, records sticky press events, counts presses and raises a maskable interrupt line. Register reads are combinational so a single-cycle load sees the value within the same cycle.

## Interface
- N_KEYS, 4, number of keys handled (1..8)
- DEBOUNCE_CYCLES, 16, consecutive stable samples required before the debounced state changes (≥2)
- clk  in  1  system clock; all state updates on rising edge
- reset_n  in  1  synchronous, active-low reset
- keys_n  in  N_KEYS  raw asynchronous keys, 0 = pressed
- sel  in  1  bus select from the I/O address decode
- addr  in  2  word offset within block (CPU addr[3:2])
- we  in  1  write strobe, qualified by sel
- wdata  in  32  write data
- rdata  out  32  read data for the current addr, combinational; 0 when sel = 0
- irq  out  1  level interrupt, |(EVENTS & MASK)

## Operation
- Register map (word offsets): 0 LEVEL (RO), 1 EVENTS (W1C), 2 COUNT (RO, write clears), 3 MASK (RW).
- LEVEL[i] = debounced state of key i, 1 = pressed; upper bits read 0.
- Input path per key: 2-FF synchroniser (reset to 1 = released), inverted to active-high, then debounce counter.
- Debounce: if sync value equals debounced state, counter <= 0; otherwise counter increments, and when counter reaches DEBOUNCE_CYCLES-1 the debounced state takes the sync value and counter <= 0. Glitches shorter than DEBOUNCE_CYCLES restart the count.
- Press event: debounced 0->1 transition sets EVENTS[i]; stays set until software writes 1 to that bit. Writing 0 has no effect.
- Same-cycle set and W1C on one bit: set wins (bit stays 1).
- COUNT: 16-bit total number of press events across all keys, wraps 0xFFFF -> 0x0000; several keys pressing in the same cycle add the number of keys (popcount). Any write to offset 2 clears it; same-cycle increment and clear: result = that cycle's increment.
- MASK[N_KEYS-1:0] read/write; upper bits ignored on write, read 0.
- Writes ignored unless sel & we. Writes to LEVEL ignored.

## Timing
- Reset values: sync FFs 1, debounced state 0, counters 0, EVENTS 0, COUNT 0, MASK 0, irq 0; rdata 0 for every offset after reset.
- Latency raw edge -> LEVEL change: 2 (sync) + DEBOUNCE_CYCLES clock edges; EVENTS bit and COUNT update on the same edge as LEVEL.
- irq is registered-state-derived combinational: high in the cycle after the edge that sets a masked EVENTS bit; falls in the cycle after the W1C or MASK clear.
- Write effects visible on the following cycle's read.
- reset_n low mid-debounce discards the count; no event is generated by reset itself, and a key held through reset is reported as a press once debounced after release of reset.

## Configuration
- IO_KEYS_RELEASE_EN defined: debounced 1->0 transitions set EVENTS[N_KEYS+i] (W1C, same set-wins rule); MASK[N_KEYS+i] is writable and gates these into irq. COUNT still counts presses only.
- Undefined: EVENTS and MASK bits [2*N_KEYS-1:N_KEYS] read 0, writes ignored, no release logic synthesised.

## Structure
- Package io_keys_pkg: register offset localparams (LEVEL, EVENTS, COUNT, MASK), COUNT width (16), data width (32).
- Sub-module key_debounce (one key: synchroniser, counter, debounced state, rise/fall pulses), instantiated N_KEYS times via generate.

## Test plan
- Reset then read all four offsets -> 0x0, 0x0, 0x0, 0x0; irq = 0.
- DEBOUNCE_CYCLES = 4: drive keys_n[1] = 0 and hold -> LEVEL = 0x2 exactly 6 edges later, EVENTS = 0x2, COUNT = 1.
- Pulse keys_n[0] low for 3 cycles, repeat 5 times -> LEVEL, EVENTS, COUNT stay 0.
- MASK = 0x2, press key 1 -> irq = 1; write EVENTS = 0x1 -> irq stays 1; write 0x2 -> irq = 0 next cycle; W1C in the same cycle as a new press edge -> bit remains 1.
- Preload COUNT to 0xFFFF via 65535 presses (or force), press keys 0 and 2 simultaneously -> COUNT = 0x0001; write offset 2 -> 0x0000.
- With IO_KEYS_RELEASE_EN: press and release key 3 -> EVENTS = 0x88; without: EVENTS = 0x08.

Source files
------------

// File: rtl/io_keys_pkg.sv
// Shared register map and widths for the io_keys push-button peripheral.
package io_keys_pkg;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned COUNT_W = 16;

    localparam logic [1:0] REG_LEVEL  = 2'd0;
    localparam logic [1:0] REG_EVENTS = 2'd1;
    localparam logic [1:0] REG_COUNT  = 2'd2;
    localparam logic [1:0] REG_MASK   = 2'd3;

endpackage

// File: rtl/io_keys_debounce.sv
// One key: 2-FF synchroniser, stable-sample debounce counter and edge pulses.
// rise_c/fall_c are high in the cycle before the edge that updates level_o.
module key_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic key_n_i,
    output logic level_o,
    output logic rise_c,
    output logic fall_c
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);

    logic             sync1_q, sync2_q;
    logic             state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             key_hi;
    logic             differ;
    logic             settle;

    always_comb begin
        key_hi  = ~sync2_q;
        differ  = (key_hi != state_q);
        settle  = differ && (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1));
        state_d = state_q;
        cnt_d   = '0;
        if (settle) begin
            state_d = key_hi;
        end else if (differ) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Synchroniser resets to released so a held key is seen as a fresh press.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            state_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= key_n_i;
            sync2_q <= sync1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level_o = state_q;
    assign rise_c  = settle & key_hi;
    assign fall_c  = settle & ~key_hi;

endmodule

// File: rtl/io_keys.sv
// Memory-mapped debounced push-button block: LEVEL, EVENTS (W1C), COUNT, MASK, irq.
// Define IO_KEYS_RELEASE_EN to also record release events in EVENTS/MASK[2*N_KEYS-1:N_KEYS].
module io_keys
    import io_keys_pkg::*;
#(
    parameter int unsigned N_KEYS          = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [N_KEYS-1:0] keys_n,
    input  logic              sel,
    input  logic [1:0]        addr,
    input  logic              we,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              irq
);

`ifdef IO_KEYS_RELEASE_EN
    localparam int unsigned EW = 2 * N_KEYS;
`else
    localparam int unsigned EW = N_KEYS;
`endif

    logic [N_KEYS-1:0]  level, rise, fall;
    logic [EW-1:0]      set_ev, ev_clr;
    logic [EW-1:0]      events_q, events_d;
    logic [EW-1:0]      mask_q, mask_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic [COUNT_W-1:0] inc;
    logic               wr;
    logic               unused_bits;

    for (genvar g = 0; g < N_KEYS; g++) begin : g_key
        key_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_deb (
            .clk     (clk),
            .reset_n (reset_n),
            .key_n_i (keys_n[g]),
            .level_o (level[g]),
            .rise_c  (rise[g]),
            .fall_c  (fall[g])
        );
    end

`ifdef IO_KEYS_RELEASE_EN
    assign set_ev      = {fall, rise};
    assign unused_bits = ^wdata[DATA_W-1:EW];
`else
    assign set_ev      = rise;
    assign unused_bits = ^{wdata[DATA_W-1:EW], fall};
`endif

    assign wr = sel & we;

    // Set has priority over a same-cycle W1C; a COUNT clear keeps this cycle's presses.
    always_comb begin
        inc = '0;
        for (int i = 0; i < N_KEYS; i++) begin
            inc = inc + COUNT_W'(rise[i]);
        end
        ev_clr   = (wr && addr == REG_EVENTS) ? wdata[EW-1:0] : '0;
        events_d = (events_q & ~ev_clr) | set_ev;
        count_d  = (wr && addr == REG_COUNT) ? inc : count_q + inc;
        mask_d   = (wr && addr == REG_MASK) ? wdata[EW-1:0] : mask_q;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            events_q <= '0;
            mask_q   <= '0;
            count_q  <= '0;
        end else begin
            events_q <= events_d;
            mask_q   <= mask_d;
            count_q  <= count_d;
        end
    end

    // Combinational read so a single-cycle load sees the value in the same cycle.
    always_comb begin
        rdata = '0;
        if (sel) begin
            case (addr)
                REG_LEVEL:  rdata = DATA_W'(level);
                REG_EVENTS: rdata = DATA_W'(events_q);
                REG_COUNT:  rdata = DATA_W'(count_q);
                default:    rdata = DATA_W'(mask_q);
            endcase
        end
    end

    assign irq = |(events_q & mask_q);

endmodule

// File: tb/tb_io_keys.sv
// Directed self-checking bench for io_keys with DEBOUNCE_CYCLES = 4 and N_KEYS = 4.
module tb_io_keys;

    localparam int unsigned NK = 4;
    localparam int unsigned DB = 4;
`ifdef IO_KEYS_RELEASE_EN
    localparam bit REL = 1'b1;
`else
    localparam bit REL = 1'b0;
`endif

    logic          clk;
    logic          reset_n;
    logic [NK-1:0] keys_n;
    logic          sel;
    logic [1:0]    addr;
    logic          we;
    logic [31:0]   wdata;
    logic [31:0]   rdata;
    logic          irq;
    logic [31:0]   rd_val;

    int assert_cnt = 0;
    int fail_cnt   = 0;

    io_keys #(
        .N_KEYS          (NK),
        .DEBOUNCE_CYCLES (DB)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .keys_n  (keys_n),
        .sel     (sel),
        .addr    (addr),
        .we      (we),
        .wdata   (wdata),
        .rdata   (rdata),
        .irq     (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        assert_cnt++;
        if (got !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        sel = 1'b1; we = 1'b1; addr = a; wdata = d;
        tick(1);
        sel = 1'b0; we = 1'b0; wdata = '0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        sel = 1'b1; we = 1'b0; addr = a;
        #1;
        d = rdata;
        sel = 1'b0;
    endtask

    function automatic logic [31:0] rel_bit(input int k);
        return REL ? (32'd1 << (NK + k)) : 32'd0;
    endfunction

    initial begin
        reset_n = 1'b0; keys_n = '1; sel = 1'b0; we = 1'b0; addr = '0; wdata = '0;
        tick(3);
        reset_n = 1'b1;

        // Reset state of all registers and irq
        for (int a = 0; a < 4; a++) begin
            bus_read(2'(a), rd_val);
            check($sformatf("reset_reg%0d", a), rd_val, 32'h0);
        end
        check("reset_irq", 32'(irq), 32'h0);

        // Press key 1: LEVEL changes exactly 2 + DB edges later
        keys_n[1] = 1'b0;
        tick(5);
        bus_read(2'd0, rd_val); check("level_before", rd_val, 32'h0);
        tick(1);
        bus_read(2'd0, rd_val); check("level_press1", rd_val, 32'h2);
        bus_read(2'd1, rd_val); check("events_press1", rd_val, 32'h2);
        bus_read(2'd2, rd_val); check("count_press1", rd_val, 32'h1);

        // Release, then W1C all events and clear COUNT
        keys_n[1] = 1'b1;
        tick(8);
        bus_read(2'd0, rd_val); check("level_release1", rd_val, 32'h0);
        bus_read(2'd1, rd_val); check("events_release1", rd_val, 32'h2 | rel_bit(1));
        bus_write(2'd1, 32'hFF);
        bus_write(2'd2, 32'h0);
        bus_read(2'd1, rd_val); check("events_cleared", rd_val, 32'h0);
        bus_read(2'd2, rd_val); check("count_cleared", rd_val, 32'h0);

        // Glitches shorter than DB are rejected
        repeat (5) begin
            keys_n[0] = 1'b0; tick(3);
            keys_n[0] = 1'b1; tick(3);
        end
        tick(4);
        bus_read(2'd0, rd_val); check("glitch_level", rd_val, 32'h0);
        bus_read(2'd1, rd_val); check("glitch_events", rd_val, 32'h0);
        bus_read(2'd2, rd_val); check("glitch_count", rd_val, 32'h0);

        // MASK / irq behaviour, W1C of 0 bits, set-wins
        bus_write(2'd3, 32'hFFFF_FF02);
        bus_read(2'd3, rd_val); check("mask_rd", rd_val, 32'h2);
        check("irq_idle", 32'(irq), 32'h0);
        keys_n[1] = 1'b0;
        tick(6);
        check("irq_press", 32'(irq), 32'h1);
        bus_write(2'd1, 32'h1);
        check("irq_w1c_other", 32'(irq), 32'h1);
        bus_write(2'd0, 32'hF);
        bus_read(2'd0, rd_val); check("level_ro", rd_val, 32'h2);
        bus_write(2'd1, 32'h2);
        check("irq_w1c", 32'(irq), 32'h0);
        keys_n[1] = 1'b1;
        tick(8);
        check("irq_release_masked", 32'(irq), 32'h0);
        bus_write(2'd1, 32'hFF);
        keys_n[1] = 1'b0;
        tick(5);
        bus_write(2'd1, 32'h2);
        bus_read(2'd1, rd_val); check("set_wins", rd_val, 32'h2);
        check("irq_set_wins", 32'(irq), 32'h1);
        bus_read(2'd2, rd_val); check("count_two", rd_val, 32'h2);
        keys_n[1] = 1'b1;
        tick(8);
        bus_write(2'd1, 32'hFF);
        bus_write(2'd3, 32'h0);

        // COUNT wrap with two simultaneous presses, then write-clear
        force dut.count_q = 16'hFFFF;
        #1;
        release dut.count_q;
        bus_read(2'd2, rd_val); check("count_preload", rd_val, 32'hFFFF);
        keys_n = 4'b1010;
        tick(6);
        bus_read(2'd2, rd_val); check("count_wrap", rd_val, 32'h1);
        bus_read(2'd0, rd_val); check("level_dual", rd_val, 32'h5);
        bus_write(2'd2, 32'h1234);
        bus_read(2'd2, rd_val); check("count_wclr", rd_val, 32'h0);
        keys_n = '1;
        tick(8);
        bus_write(2'd1, 32'hFF);

        // Press and release key 3
        keys_n[3] = 1'b0; tick(6);
        keys_n[3] = 1'b1; tick(8);
        bus_read(2'd1, rd_val); check("events_key3", rd_val, 32'h08 | rel_bit(3));
        bus_read(2'd2, rd_val); check("count_key3", rd_val, 32'h1);
        addr = 2'd2; sel = 1'b0; #1;
        check("rdata_unsel", rdata, 32'h0);

        // Key held through reset is reported once debounced afterwards
        keys_n[0] = 1'b0;
        tick(4);
        reset_n = 1'b0;
        tick(2);
        reset_n = 1'b1;
        bus_read(2'd2, rd_val); check("count_after_rst", rd_val, 32'h0);
        tick(5);
        bus_read(2'd0, rd_val); check("level_rst_pre", rd_val, 32'h0);
        tick(1);
        bus_read(2'd0, rd_val); check("level_rst_held", rd_val, 32'h1);
        bus_read(2'd1, rd_val); check("events_rst_held", rd_val, 32'h1);
        bus_read(2'd2, rd_val); check("count_rst_held", rd_val, 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end

endmodule
